// File: rtl/pc_fetch_if.sv
// Fetch request channel between the PC sequencer (master) and the memory controller (slave).
interface pc_fetch_if #(
   parameter int unsigned DATA_WIDTH = 32
) ();
   logic                  fetch_req;
   logic                  fetch_ready;
   logic [DATA_WIDTH-1:0] fetch_addr;

   modport master (output fetch_req, output fetch_addr, input fetch_ready);
   modport slave  (input fetch_req, input fetch_addr, output fetch_ready);
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage program counter: prioritised next-PC selection, circular return-address
// stack, and a BOOT/RUN/HALT sequencer gating fetch requests.
module pc_fetch_sequencer #(
   parameter int unsigned                 DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0]       RESET_VECTOR = '0,
   parameter logic [DATA_WIDTH-1:0]       TRAP_VECTOR  = DATA_WIDTH'(32'h100),
   parameter int unsigned                 PC_STEP      = 4,
   parameter int unsigned                 ALIGN_BITS   = 2,
   parameter int unsigned                 RAS_DEPTH    = 4,
   localparam int unsigned                PTR_W        = $clog2(RAS_DEPTH),
   localparam int unsigned                CNT_W        = PTR_W + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  halt,
   input  logic                  resume,
   input  logic                  trap,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   input  logic                  ras_push,
   input  logic                  ras_pop,
   pc_fetch_if.master            fetch,
   output logic [DATA_WIDTH-1:0] pc,
   output logic [CNT_W-1:0]      ras_count,
   output logic                  ras_overflow,
   output logic                  ras_underflow,
   output logic                  misalign
);

   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = DATA_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
   localparam logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(PC_STEP);
   localparam logic [CNT_W-1:0]      FULL       = CNT_W'(RAS_DEPTH);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [DATA_WIDTH-1:0] ras_d [RAS_DEPTH];
   logic [PTR_W-1:0]      top_q, top_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  ovf_q, ovf_d, unf_q, unf_d, mis_q, mis_d;

   logic                  run, advance;
   logic [DATA_WIDTH-1:0] pc_seq;
   logic [PTR_W-1:0]      top_inc, top_dec;

   assign run     = (state_q == RUN);
   assign advance = run && fetch.fetch_ready && !stall;
   assign pc_seq  = pc_q + STEP;
   assign top_inc = top_q + PTR_W'(1);
   assign top_dec = top_q - PTR_W'(1);

   // Next-state, next-PC and RAS update; trap and redirect freeze the RAS.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ras_d   = ras_q;
      top_d   = top_q;
      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      mis_d   = 1'b0;

      unique case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (halt && !trap && !redirect_valid) state_d = HALT;
         HALT:    if (resume || trap) state_d = RUN;
         default: state_d = BOOT;
      endcase

      if ((run || state_q == HALT) && trap) begin
         pc_d = TRAP_VECTOR;
      end else if (run && redirect_valid) begin
         pc_d  = redirect_pc & ~ALIGN_MASK;
         mis_d = |(redirect_pc & ALIGN_MASK);
      end else if (advance) begin
         pc_d = pc_seq;
         if (ras_push && ras_pop && count_q != '0) begin
            pc_d         = ras_q[top_q];
            ras_d[top_q] = pc_seq;
         end else if (ras_push) begin
            ras_d[top_inc] = pc_seq;
            top_d          = top_inc;
            if (count_q == FULL) ovf_d = 1'b1;
            else                 count_d = count_q + CNT_W'(1);
         end else if (ras_pop) begin
            if (count_q != '0) begin
               pc_d    = ras_q[top_q];
               top_d   = top_dec;
               count_d = count_q - CNT_W'(1);
            end else begin
               unf_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         top_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         mis_q   <= 1'b0;
         for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         top_q   <= top_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         mis_q   <= mis_d;
         ras_q   <= ras_d;
      end
   end

   assign fetch.fetch_req  = run;
   assign fetch.fetch_addr = pc_q;
   assign pc               = pc_q;
   assign ras_count        = count_q;
   assign ras_overflow     = ovf_q;
   assign ras_underflow    = unf_q;
   assign misalign         = mis_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: sequencing, stalls, RAS, trap/redirect, wrap, HALT.
module tb_pc_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, halt, resume, trap, redirect_valid, ras_push, ras_pop;
   logic [31:0] redirect_pc;
   logic [31:0] pc;
   logic [2:0]  ras_count;
   logic        ras_overflow, ras_underflow, misalign;
   int          checks = 0;
   int          errors = 0;

   pc_fetch_if #(.DATA_WIDTH(32)) bus ();

   pc_fetch_sequencer dut (
      .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume), .trap(trap),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ras_push(ras_push), .ras_pop(ras_pop), .fetch(bus.master), .pc(pc),
      .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow),
      .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      stall = 0; halt = 0; resume = 0; trap = 0; redirect_valid = 0; redirect_pc = '0;
      ras_push = 0; ras_pop = 0; bus.fetch_ready = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clr_in();
      #12;
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.fetch_req); end
      checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", ras_count); end
      step();
      rst = 1'b1;
      #1;
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b exp 0", bus.fetch_req); end
      step();
      checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h0) begin
         errors++; $display("FAIL run_first got req %b addr %h exp 1 %h", bus.fetch_req, bus.fetch_addr, 32'h0); end
   endtask

   task automatic test_sequential();
      bus.fetch_ready = 1;
      step();
      checks++; if (bus.fetch_addr !== 32'h4) begin errors++; $display("FAIL seq_4 got %h exp %h", bus.fetch_addr, 32'h4); end
      step();
      checks++; if (bus.fetch_addr !== 32'h8) begin errors++; $display("FAIL seq_8 got %h exp %h", bus.fetch_addr, 32'h8); end
      bus.fetch_ready = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (pc !== 32'h8 || bus.fetch_req !== 1'b1) begin
            errors++; $display("FAIL notready_hold%0d got pc %h req %b exp %h 1", i, pc, bus.fetch_req, 32'h8); end
      end
      stall = 1; bus.fetch_ready = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_hold%0d got %h exp %h", i, pc, 32'h8); end
      end
      stall = 0;
      step();
      checks++; if (pc !== 32'hC) begin errors++; $display("FAIL seq_12 got %h exp %h", pc, 32'hC); end
      clr_in();
   endtask

   task automatic test_call_return();
      redirect_valid = 1; redirect_pc = 32'h40;
      step();
      checks++; if (pc !== 32'h40) begin errors++; $display("FAIL call_redir got %h exp %h", pc, 32'h40); end
      redirect_valid = 0; bus.fetch_ready = 1; ras_push = 1;
      step();
      checks++; if (pc !== 32'h44 || ras_count !== 3'd1) begin
         errors++; $display("FAIL call_push got pc %h cnt %0d exp %h 1", pc, ras_count, 32'h44); end
      ras_push = 0; bus.fetch_ready = 0; redirect_valid = 1; redirect_pc = 32'h80;
      step();
      checks++; if (pc !== 32'h80) begin errors++; $display("FAIL call_body got %h exp %h", pc, 32'h80); end
      redirect_valid = 0; bus.fetch_ready = 1; ras_pop = 1;
      step();
      checks++; if (pc !== 32'h44 || ras_count !== 3'd0) begin
         errors++; $display("FAIL return_pop got pc %h cnt %0d exp %h 0", pc, ras_count, 32'h44); end
      clr_in();
   endtask

   task automatic test_ras_overflow_underflow();
      logic [31:0] exp_pc;
      logic [2:0]  exp_cnt;
      redirect_valid = 1; redirect_pc = 32'h1000;
      step();
      redirect_valid = 0; bus.fetch_ready = 1; ras_push = 1;
      for (int i = 1; i <= 5; i++) begin
         step();
         exp_pc  = 32'h1000 + 32'(4 * i);
         exp_cnt = (i > 4) ? 3'd4 : 3'(i);
         checks++; if (pc !== exp_pc || ras_count !== exp_cnt || ras_overflow !== (i == 5)) begin
            errors++; $display("FAIL push%0d got pc %h cnt %0d ovf %b exp %h %0d %b",
                               i, pc, ras_count, ras_overflow, exp_pc, exp_cnt, (i == 5)); end
      end
      ras_push = 0; bus.fetch_ready = 0; redirect_valid = 1; redirect_pc = 32'h2000;
      step();
      checks++; if (ras_overflow !== 1'b0 || pc !== 32'h2000 || ras_count !== 3'd4) begin
         errors++; $display("FAIL ovf_clear got ovf %b pc %h cnt %0d exp 0 %h 4", ras_overflow, pc, ras_count, 32'h2000); end
      redirect_valid = 0; bus.fetch_ready = 1; ras_pop = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         exp_pc  = 32'h1014 - 32'(4 * i);
         exp_cnt = 3'(3 - i);
         checks++; if (pc !== exp_pc || ras_count !== exp_cnt || ras_underflow !== 1'b0) begin
            errors++; $display("FAIL pop%0d got pc %h cnt %0d unf %b exp %h %0d 0",
                               i, pc, ras_count, ras_underflow, exp_pc, exp_cnt); end
      end
      step();
      checks++; if (pc !== 32'h100C || ras_count !== 3'd0 || ras_underflow !== 1'b1) begin
         errors++; $display("FAIL pop_empty got pc %h cnt %0d unf %b exp %h 0 1", pc, ras_count, ras_underflow, 32'h100C); end
      ras_pop = 0; bus.fetch_ready = 0;
      step();
      checks++; if (ras_underflow !== 1'b0 || pc !== 32'h100C) begin
         errors++; $display("FAIL unf_clear got unf %b pc %h exp 0 %h", ras_underflow, pc, 32'h100C); end
      clr_in();
   endtask

   task automatic test_trap_redirect();
      bus.fetch_ready = 1; ras_push = 1;
      step();
      checks++; if (pc !== 32'h1010 || ras_count !== 3'd1) begin
         errors++; $display("FAIL pre_push got pc %h cnt %0d exp %h 1", pc, ras_count, 32'h1010); end
      ras_push = 0; trap = 1; redirect_valid = 1; redirect_pc = 32'h200; ras_pop = 1;
      step();
      checks++; if (pc !== 32'h100 || ras_count !== 3'd1 || misalign !== 1'b0) begin
         errors++; $display("FAIL trap_prio got pc %h cnt %0d mis %b exp %h 1 0", pc, ras_count, misalign, 32'h100); end
      trap = 0; ras_pop = 0; bus.fetch_ready = 0; redirect_pc = 32'h203;
      step();
      checks++; if (pc !== 32'h200 || misalign !== 1'b1) begin
         errors++; $display("FAIL misalign got pc %h mis %b exp %h 1", pc, misalign, 32'h200); end
      redirect_valid = 0;
      step();
      checks++; if (pc !== 32'h200 || misalign !== 1'b0) begin
         errors++; $display("FAIL misalign_clear got pc %h mis %b exp %h 0", pc, misalign, 32'h200); end
      bus.fetch_ready = 1; ras_pop = 1;
      step();
      checks++; if (pc !== 32'h1010 || ras_count !== 3'd0) begin
         errors++; $display("FAIL ras_kept got pc %h cnt %0d exp %h 0", pc, ras_count, 32'h1010); end
      clr_in();
   endtask

   task automatic test_wrap_halt();
      redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
      step();
      checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got %h exp %h", pc, 32'hFFFF_FFFC); end
      redirect_valid = 0; bus.fetch_ready = 1;
      step();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap got %h exp %h", pc, 32'h0); end
      bus.fetch_ready = 0; halt = 1;
      step();
      checks++; if (bus.fetch_req !== 1'b0 || pc !== 32'h0) begin
         errors++; $display("FAIL halt_enter got req %b pc %h exp 0 %h", bus.fetch_req, pc, 32'h0); end
      halt = 0; bus.fetch_ready = 1; redirect_valid = 1; redirect_pc = 32'h300;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (bus.fetch_req !== 1'b0 || pc !== 32'h0) begin
            errors++; $display("FAIL halt_hold%0d got req %b pc %h exp 0 %h", i, bus.fetch_req, pc, 32'h0); end
      end
      redirect_valid = 0; resume = 1;
      step();
      checks++; if (bus.fetch_req !== 1'b1 || pc !== 32'h0) begin
         errors++; $display("FAIL resume got req %b pc %h exp 1 %h", bus.fetch_req, pc, 32'h0); end
      resume = 0;
      step();
      checks++; if (pc !== 32'h4) begin errors++; $display("FAIL resume_fetch got %h exp %h", pc, 32'h4); end
      bus.fetch_ready = 0; halt = 1;
      step();
      halt = 0; trap = 1;
      step();
      checks++; if (bus.fetch_req !== 1'b1 || pc !== 32'h100) begin
         errors++; $display("FAIL halt_trap got req %b pc %h exp 1 %h", bus.fetch_req, pc, 32'h100); end
      trap = 0; halt = 1;
      step();
      halt = 0;
      #3;
      rst = 1'b0;
      #1;
      checks++; if (pc !== 32'h0 || bus.fetch_req !== 1'b0 || ras_count !== 3'd0) begin
         errors++; $display("FAIL async_rst got pc %h req %b cnt %0d exp %h 0 0", pc, bus.fetch_req, ras_count, 32'h0); end
      step();
      rst = 1'b1;
      step();
      checks++; if (bus.fetch_req !== 1'b1 || pc !== 32'h0) begin
         errors++; $display("FAIL rst_reboot got req %b pc %h exp 1 %h", bus.fetch_req, pc, 32'h0); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_call_return();
      test_ras_overflow_underflow();
      test_trap_redirect();
      test_wrap_halt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
